inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Upstream neighbour of the main control decoder. Owns the PC and drives a req/gnt/rvalid instruction-memory handshake.
//  Holds the fetched word in an instruction register and offers it downstream with valid/ready; op = instr[31:26] feeds the decoder.
//  Next-PC selection (PC+4 / BEQ target / J target) happens on the accept handshake, using branch/jump results returned by the datapath.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset; must be word aligned
//  CNT_W      32             width of performance counters (FETCH_PERF_CNT_EN only)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous, active-low reset
//  imem_req     out  1   fetch request
//  imem_addr    out  32  byte address of request (= pc)
//  imem_gnt     in   1   memory accepted request this cycle
//  imem_rvalid  in   1   read data valid
//  imem_rdata   in   32  instruction word
//  instr        out  32  held instruction (op = instr[31:26])
//  instr_valid  out  1   instr is valid for consumption
//  instr_ready  in   1   downstream consumes instr this cycle
//  pc           out  32  address of held instruction
//  pc_plus4     out  32  pc + 4 (mod 2^32)
//  jump         in   1   decoder jump, sampled on accept
//  branch_taken in   1   branch & zero, sampled on accept
//  imm_ext      in   32  sign-extended imm16, sampled on accept
//  perf_fetch   out  CNT_W instructions accepted (macro only)
//  perf_stall   out  CNT_W cycles valid&!ready (macro only)
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, state=IDLE, imem_req=0, instr=0, instr_valid=0, perf counters=0.
//  FSM: IDLE -> REQ (unconditional, 1st cycle after release).
//   REQ : imem_req=1, imem_addr=pc held stable; imem_gnt -> WAIT.
//   WAIT: imem_req=0; imem_rvalid -> capture imem_rdata into instr, instr_valid=1, -> HOLD.
//   HOLD: instr_valid=1, instr stable until instr_valid&instr_ready; then instr_valid=0, pc=next_pc, -> REQ.
//  next_pc priority: jump -> {pc_plus4[31:28], instr[25:0], 2'b00};
//   else branch_taken -> pc_plus4 + (imm_ext<<2); else pc_plus4. Jump wins if both high.
//  All adds wrap modulo 2^32 (pc=32'hFFFF_FFFC -> next 32'h0000_0000); no overflow flag.
//  Best-case throughput: 1 instr / 3 cycles (gnt in REQ, rvalid next cycle, ready in HOLD).
//  gnt and rvalid in same cycle while in REQ: gnt honoured only; rvalid is legal only in WAIT.
//  imem_rvalid outside WAIT is ignored (covers stale response after reset mid-WAIT).
//  jump/branch_taken/imm_ext ignored except on accept cycle.
//  Reset asserted in any state: immediately returns to reset values; outstanding fetch abandoned.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: perf_fetch += 1 on each accept; perf_stall += 1 each cycle instr_valid&!instr_ready;
//   both saturate at all-ones; cleared only by reset.
//  Not defined: perf_fetch, perf_stall tied to 0, no counter flops.
// STRUCTURE
//  cpu_pkg: fetch state enum {IDLE,REQ,WAIT,HOLD}, OP_J=6'b000010, OP_BEQ=6'b000100, RESET_PC default, word size 4.
//  Sub-module pc_next_sel (combinational next_pc mux + adders); FSM, instr register, counters in top.
// TESTING
//  Reset, gnt=1 always, rvalid 1 cycle after gnt, ready=1, no redirects -> imem_addr 0,4,8 on successive REQ cycles, 3 cycles apart.
//  Accept at pc=0x10 with branch_taken=1, imm_ext=32'hFFFF_FFFE -> next imem_addr=0x0C.
//  Accept instr=32'h0800_0040 with jump=1 and branch_taken=1 at pc=0x1000_0000 -> next imem_addr=0x1000_0100.
//  Hold instr_ready=0 for 5 cycles -> instr/pc stable, instr_valid=1, no imem_req; perf_stall=5 (macro on).
//  Assert rst_n=0 in WAIT, release, rvalid pulse in REQ -> ignored, imem_addr=RESET_PC, instr_valid=0.
//  pc=32'hFFFF_FFFC accepted, no redirect -> next imem_addr=32'h0000_0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and fetch-FSM encodings used by the fetch unit and its next-PC logic.
package cpu_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES       = 32'd4;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t IDLE = 2'd0;
  localparam fetch_state_t REQ  = 2'd1;
  localparam fetch_state_t WAIT = 2'd2;
  localparam fetch_state_t HOLD = 2'd3;

  // Branch offsets are in words; convert to a byte displacement (wraps mod 2^32).
  function automatic logic [31:0] word_offset(input logic [31:0] imm);
    return imm << 2;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_pc_next_sel.sv
// Combinational next-PC selection: jump target beats branch target beats sequential PC+4.
module pc_next_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] jump_index,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [31:0] imm_ext,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  assign pc_plus4 = pc + WORD_BYTES;

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + word_offset(imm_ext);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, runs the req/gnt/rvalid memory handshake, holds the instruction for the decoder.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic             jump,
  input  logic             branch_taken,
  input  logic [31:0]      imm_ext,
  output logic [CNT_W-1:0] perf_fetch,
  output logic [CNT_W-1:0] perf_stall
);

  fetch_state_t state;
  logic [31:0]  next_pc;
  logic         accept;

  assign accept    = instr_valid & instr_ready;
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  pc_next_sel u_pc_next_sel (
    .pc           (pc),
    .jump_index   (instr[25:0]),
    .jump         (jump),
    .branch_taken (branch_taken),
    .imm_ext      (imm_ext),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc)
  );

  // A response is only taken in WAIT, so stale rvalid after a mid-fetch reset falls on the floor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_gnt) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            instr_valid <= 1'b0;
            pc          <= next_pc;
            state       <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             stall;

  assign stall = instr_valid & ~instr_ready;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && fetch_cnt != '1) fetch_cnt <= fetch_cnt + CNT_ONE;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign perf_fetch = fetch_cnt;
  assign perf_stall = stall_cnt;
`else
  assign perf_fetch = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: vector table, directed redirect/stall/reset sequences, random traffic vs a reference model.
module tb_inst_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        jump;
  logic        branch_taken;
  logic [31:0] imm_ext;
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;

  int errors = 0;
  int checks = 0;

  inst_fetch_unit #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .jump         (jump),
    .branch_taken (branch_taken),
    .imm_ext      (imm_ext),
    .perf_fetch   (perf_fetch),
    .perf_stall   (perf_stall)
  );

  always #5 clk = ~clk;

  // Reference model: where the fetch transaction stands (0 = just out of reset,
  // 1 = requesting, 2 = awaiting data, 3 = holding an instruction).
  int          m_phase;
  logic [31:0] m_pc, m_instr, m_fetch, m_stall;

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                           input logic j, input logic b, input logic [31:0] imm);
    logic [31:0] seq;
    seq = p + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    if (b) return seq + imm * 32'd4;
    return seq;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pc = RST_PC; m_instr = 32'h0; m_fetch = 0; m_stall = 0;
  endtask

  task automatic model_step();
    case (m_phase)
      0: m_phase = 1;
      1: if (imem_gnt) m_phase = 2;
      2: if (imem_rvalid) begin m_instr = imem_rdata; m_phase = 3; end
      default: begin
        if (instr_ready) begin
          m_pc = ref_next(m_pc, m_instr, jump, branch_taken, imm_ext);
          if (m_fetch != 32'hFFFF_FFFF) m_fetch = m_fetch + 1;
          m_phase = 1;
        end else if (m_stall != 32'hFFFF_FFFF) begin
          m_stall = m_stall + 1;
        end
      end
    endcase
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the clock edge, return at the next falling edge.
  task automatic applyStimulus(input logic r, input logic g, input logic v, input logic [31:0] d,
                               input logic rdy, input logic j, input logic b, input logic [31:0] imm);
    rst_n = r; imem_gnt = g; imem_rvalid = v; imem_rdata = d;
    instr_ready = rdy; jump = j; branch_taken = b; imm_ext = imm;
    if (!r) model_reset();
    @(posedge clk);
    if (r) model_step();
    @(negedge clk);
  endtask

  task automatic checkOutput();
    cmp("imem_req", {31'b0, imem_req}, {31'b0, m_phase == 1});
    cmp("imem_addr", imem_addr, m_pc);
    cmp("pc", pc, m_pc);
    cmp("pc_plus4", pc_plus4, m_pc + 32'd4);
    cmp("instr_valid", {31'b0, instr_valid}, {31'b0, m_phase == 3});
    cmp("instr", instr, m_instr);
`ifdef FETCH_PERF_CNT_EN
    cmp("perf_fetch", perf_fetch, m_fetch);
    cmp("perf_stall", perf_stall, m_stall);
`else
    cmp("perf_fetch", perf_fetch, 32'h0);
    cmp("perf_stall", perf_stall, 32'h0);
`endif
  endtask

  // Full fetch starting in REQ: grant, data, then accept with the given redirect inputs.
  task automatic fetch_one(input logic [31:0] word, input logic j, input logic b, input logic [31:0] imm);
    applyStimulus(1, 1, 0, 32'h0, 0, 0, 0, 32'h0); checkOutput();
    applyStimulus(1, 0, 1, word, 0, 0, 0, 32'h0); checkOutput();
    applyStimulus(1, 0, 0, 32'h0, 1, j, b, imm); checkOutput();
  endtask

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[11];
  logic [31:0] stall_before, held_instr, held_pc;

  initial begin
    vecs[0]  = '{0, 0, 32'h0,         0, 1, 32'h0, 0};
    vecs[1]  = '{1, 0, 32'h0,         0, 0, 32'h0, 0};
    vecs[2]  = '{0, 1, 32'h2000_0001, 0, 0, 32'h0, 1};
    vecs[3]  = '{0, 0, 32'h0,         1, 1, 32'h4, 0};
    vecs[4]  = '{1, 0, 32'h0,         0, 0, 32'h4, 0};
    vecs[5]  = '{0, 1, 32'h3000_0002, 0, 0, 32'h4, 1};
    vecs[6]  = '{0, 0, 32'h0,         1, 1, 32'h8, 0};
    vecs[7]  = '{1, 1, 32'hDEAD_BEEF, 0, 0, 32'h8, 0};
    vecs[8]  = '{0, 0, 32'h0,         0, 0, 32'h8, 0};
    vecs[9]  = '{0, 1, 32'h4000_0003, 0, 0, 32'h8, 1};
    vecs[10] = '{0, 0, 32'h0,         1, 1, 32'hC, 0};

    applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 1, 32'h1234_5678, 1, 0, 0, 32'h0);
    checkOutput();
    cmp("reset_req", {31'b0, imem_req}, 32'h0);
    cmp("reset_instr", instr, 32'h0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(1, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].ready, 0, 0, 32'h0);
      checkOutput();
      cmp("vec_req", {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
      cmp("vec_addr", imem_addr, vecs[i].exp_addr);
      cmp("vec_valid", {31'b0, instr_valid}, {31'b0, vecs[i].exp_valid});
    end

    fetch_one(32'h0, 0, 0, 32'h0);
    cmp("seq_0x10", imem_addr, 32'h0000_0010);
    fetch_one(32'h1000_0000, 0, 1, 32'hFFFF_FFFE);
    cmp("branch_back", imem_addr, 32'h0000_000C);
    fetch_one(32'h1000_0000, 0, 1, 32'h03FF_FFFC);
    cmp("branch_fwd", imem_addr, 32'h1000_0000);
    fetch_one(32'h0800_0040, 1, 1, 32'h0000_0100);
    cmp("jump_wins", imem_addr, 32'h1000_0100);
    fetch_one(32'h0, 0, 1, 32'h3BFF_FFBE);
    cmp("to_top", imem_addr, 32'hFFFF_FFFC);
    fetch_one(32'h0, 0, 0, 32'h0);
    cmp("wrap", imem_addr, 32'h0000_0000);

    applyStimulus(1, 1, 0, 32'h0, 0, 0, 0, 32'h0); checkOutput();
    applyStimulus(1, 0, 1, 32'h0BAD_F00D, 0, 0, 0, 32'h0); checkOutput();
    stall_before = perf_stall;
    held_instr = instr;
    held_pc = pc;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 1, $urandom, 0, 1, 1, $urandom); checkOutput();
      cmp("stall_instr", instr, 32'h0BAD_F00D);
      cmp("stall_pc", pc, held_pc);
      cmp("stall_valid", {31'b0, instr_valid}, 32'h1);
      cmp("stall_req", {31'b0, imem_req}, 32'h0);
    end
`ifdef FETCH_PERF_CNT_EN
    cmp("stall_count", perf_stall - stall_before, 32'd5);
`else
    cmp("stall_count", perf_stall - stall_before, 32'd0);
`endif
    cmp("held_instr", held_instr, 32'h0BAD_F00D);
    applyStimulus(1, 0, 0, 32'h0, 1, 0, 0, 32'h0); checkOutput();

    applyStimulus(1, 1, 0, 32'h0, 0, 0, 0, 32'h0); checkOutput();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 32'h0); checkOutput();
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 0, 32'h0); checkOutput();
    applyStimulus(1, 0, 1, 32'hCAFE_0001, 1, 0, 0, 32'h0); checkOutput();
    cmp("stale_addr", imem_addr, RST_PC);
    cmp("stale_valid", {31'b0, instr_valid}, 32'h0);
    cmp("stale_req", {31'b0, imem_req}, 32'h1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 63) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom, $urandom_range(0, 1), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 2) == 0), $urandom);
      checkOutput();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
